// File: rtl/phy_tx_sched.sv
// -----------------------------------------------------------------------------
// phy_tx_sched
//
// Word scheduler in front of the transmit PHY. Two requesters share the 32-bit
// input_bus under round-robin arbitration, and words are launched at a fixed
// pace of one per WORD_PERIOD clocks. After reset, a burst of TRAIN_WORDS
// comma words is sent for link training. After that, every slot that no
// requester claims is filled with a comma idle word, so the serial lanes
// always have data.
//
// Parameters
//   WORD_PERIOD : clk cycles per word slot (>= 2)
//   TRAIN_WORDS : comma words sent after reset before requesters are served (>= 1)
//   COM         : comma symbol; idle/training word is {4{COM}}
//
// Ports
//   clk          in   1   single clock for all state
//   reset        in   1   asynchronous, active-high reset
//   req0_data    in  32   requester 0 word
//   req0_valid   in   1   requester 0 has a word
//   req0_ready   out  1   requester 0 word accepted this cycle (combinational)
//   req1_data    in  32   requester 1 word
//   req1_valid   in   1   requester 1 has a word
//   req1_ready   out  1   requester 1 word accepted this cycle (combinational)
//   input_bus    out 32   word to the PHY (registered)
//   valid        out  1   input_bus holds a link word (registered)
//   is_com       out  1   current word is a comma fill/training word (registered)
//   grant        out  2   one-hot source of current word, 2'b00 = comma (registered)
//   train_done   out  1   training burst complete (registered)
// -----------------------------------------------------------------------------
module phy_tx_sched #(
    parameter int unsigned WORD_PERIOD = 4,
    parameter int unsigned TRAIN_WORDS = 4,
    parameter logic [7:0]  COM         = 8'hBC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [31:0] input_bus,
    output logic        valid,
    output logic        is_com,
    output logic [1:0]  grant,
    output logic        train_done
);

    localparam int unsigned SLOT_W  = (WORD_PERIOD > 2) ? $clog2(WORD_PERIOD) : 1;
    localparam int unsigned TRAIN_W = $clog2(TRAIN_WORDS + 1);

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(WORD_PERIOD - 1);
    localparam logic [TRAIN_W-1:0] TRAIN_LAST = TRAIN_W'(TRAIN_WORDS - 1);
    localparam logic [31:0]        COM_WORD   = {4{COM}};

    typedef enum logic [0:0] {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // FSM and bookkeeping state
    state_e              state_q,      state_d;
    logic [SLOT_W-1:0]   slot_cnt_q,   slot_cnt_d;
    logic [TRAIN_W-1:0]  train_cnt_q,  train_cnt_d;
    logic                last_grant_q, last_grant_d;

    // Registered outputs
    logic [31:0]         bus_q,        bus_d;
    logic                valid_q,      valid_d;
    logic                is_com_q,     is_com_d;
    logic [1:0]          grant_q,      grant_d;
    logic                train_done_q, train_done_d;

    // Decoded per-cycle conditions
    logic                launch_s;
    logic                train_last_s;
    logic                pick0_s;
    logic                pick1_s;

    // Round-robin choice between requesters. last_grant is the index of the
    // most recently served requester; on a tie the other one wins.
    function automatic logic [1:0] rr_pick(input logic v0, input logic v1,
                                           input logic last);
        logic [1:0] pick;
        pick = 2'b00;
        if (v0 && v1) begin
            pick = last ? 2'b01 : 2'b10;
        end else if (v0) begin
            pick = 2'b01;
        end else if (v1) begin
            pick = 2'b10;
        end else begin
            pick = 2'b00;
        end
        return pick;
    endfunction

    // Slot decode and arbitration result for the current cycle
    always_comb begin
        launch_s              = (slot_cnt_q == SLOT_LAST);
        train_last_s          = (train_cnt_q == TRAIN_LAST);
        {pick1_s, pick0_s}    = rr_pick(req0_valid, req1_valid, last_grant_q);
    end

    // Slot counter next value: wraps after the launch cycle
    always_comb begin
        slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        if (launch_s) begin
            slot_cnt_d = '0;
        end else begin
            slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end
    end

    // Slot counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q <= '0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_TRAIN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: TRAIN ends on the launch of the last training word,
    // RUN is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_TRAIN: begin
                if (launch_s && train_last_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_TRAIN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_TRAIN;
            end
        endcase
    end

    // FSM outputs: handshake strobes and next values of the word registers.
    // Everything holds between launches.
    always_comb begin
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        train_cnt_d  = train_cnt_q;
        last_grant_d = last_grant_q;
        bus_d        = bus_q;
        valid_d      = valid_q;
        is_com_d     = is_com_q;
        grant_d      = grant_q;
        train_done_d = train_done_q;
        case (state_q)
            ST_TRAIN: begin
                if (launch_s) begin
                    bus_d       = COM_WORD;
                    valid_d     = 1'b1;
                    is_com_d    = 1'b1;
                    grant_d     = 2'b00;
                    train_cnt_d = train_cnt_q + TRAIN_W'(1);
                    if (train_last_s) begin
                        train_done_d = 1'b1;
                    end else begin
                        train_done_d = train_done_q;
                    end
                end else begin
                    train_cnt_d = train_cnt_q;
                end
            end
            ST_RUN: begin
                if (launch_s) begin
                    valid_d    = 1'b1;
                    req0_ready = pick0_s;
                    req1_ready = pick1_s;
                    if (pick0_s) begin
                        bus_d        = req0_data;
                        is_com_d     = 1'b0;
                        grant_d      = 2'b01;
                        last_grant_d = 1'b0;
                    end else if (pick1_s) begin
                        bus_d        = req1_data;
                        is_com_d     = 1'b0;
                        grant_d      = 2'b10;
                        last_grant_d = 1'b1;
                    end else begin
                        // Nobody asked: fill the slot with an idle comma word
                        bus_d        = COM_WORD;
                        is_com_d     = 1'b1;
                        grant_d      = 2'b00;
                        last_grant_d = last_grant_q;
                    end
                end else begin
                    req0_ready = 1'b0;
                    req1_ready = 1'b0;
                end
            end
            default: begin
                req0_ready = 1'b0;
                req1_ready = 1'b0;
            end
        endcase
    end

    // Training counter and round-robin history
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            train_cnt_q  <= '0;
            last_grant_q <= 1'b1;   // makes requester 0 win the first tie
        end else begin
            train_cnt_q  <= train_cnt_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Word output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_q        <= 32'h0000_0000;
            valid_q      <= 1'b0;
            is_com_q     <= 1'b0;
            grant_q      <= 2'b00;
            train_done_q <= 1'b0;
        end else begin
            bus_q        <= bus_d;
            valid_q      <= valid_d;
            is_com_q     <= is_com_d;
            grant_q      <= grant_d;
            train_done_q <= train_done_d;
        end
    end

    assign input_bus  = bus_q;
    assign valid      = valid_q;
    assign is_com     = is_com_q;
    assign grant      = grant_q;
    assign train_done = train_done_q;

endmodule
